// File: rtl/iq_sweep_ctrl.sv
// LO divider sweep sequencer: per divider restarts the LO, settles, integrates
// the I/Q bit streams, reports a magnitude metric and tracks the best divider.
module iq_sweep_ctrl #(
  parameter int DIV_MIN = 5,
  parameter int DIV_MAX = 8,
  parameter int SETTLE  = 16,
  parameter int DWELL   = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk_27m,
  input  logic             rst_n,
  input  logic             start,
  input  logic             i_bit,
  input  logic             q_bit,
  output logic [7:0]       lo_div,
  output logic             lo_restart,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_div,
  output logic [CNT_W:0]   res_mag,
  output logic             done,
  output logic [7:0]       best_div,
  output logic [CNT_W:0]   best_mag
);

  localparam int TW = (CNT_W > $clog2(SETTLE + 1)) ? CNT_W : $clog2(SETTLE + 1);
  localparam logic [7:0]    DIV_FIRST  = 8'(DIV_MIN);
  localparam logic [7:0]    DIV_LAST   = 8'(DIV_MAX);
  localparam logic [TW-1:0] SETTLE_END = TW'(SETTLE - 1);
  localparam logic [TW-1:0] DWELL_END  = TW'(DWELL - 1);
  localparam logic signed [CNT_W+1:0] DWELL_S = (CNT_W+2)'(DWELL);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_INTEG,
    ST_REPORT,
    ST_FINISH
  } state_t;

  state_t            state_reg;
  logic [TW-1:0]     cnt_reg;
  logic [CNT_W-1:0]  i_cnt_reg;
  logic [CNT_W-1:0]  q_cnt_reg;
  logic [7:0]        run_div_reg;
  logic [CNT_W:0]    run_mag_reg;
  logic              run_first_reg;

  // The metric includes the sample of the last INTEG cycle, so it is formed
  // from the counters plus the current bits.
  logic [CNT_W-1:0]        i_sum, q_sum;
  logic signed [CNT_W+1:0] i_dev, q_dev;
  logic [CNT_W:0]          i_abs, q_abs, mag;

  assign i_sum = i_cnt_reg + CNT_W'(i_bit);
  assign q_sum = q_cnt_reg + CNT_W'(q_bit);
  assign i_dev = $signed({1'b0, i_sum, 1'b0}) - DWELL_S;
  assign q_dev = $signed({1'b0, q_sum, 1'b0}) - DWELL_S;
  assign i_abs = i_dev[CNT_W+1] ? (CNT_W+1)'(-i_dev) : i_dev[CNT_W:0];
  assign q_abs = q_dev[CNT_W+1] ? (CNT_W+1)'(-q_dev) : q_dev[CNT_W:0];
  assign mag   = i_abs + q_abs;

  always_ff @(posedge clk_27m) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      i_cnt_reg     <= '0;
      q_cnt_reg     <= '0;
      run_div_reg   <= '0;
      run_mag_reg   <= '0;
      run_first_reg <= 1'b0;
      lo_div        <= DIV_FIRST;
      lo_restart    <= 1'b0;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
      res_div       <= '0;
      res_mag       <= '0;
      done          <= 1'b0;
      best_div      <= '0;
      best_mag      <= '0;
    end else begin
      lo_restart <= 1'b0;
      done       <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg     <= ST_SETTLE;
            busy          <= 1'b1;
            lo_div        <= DIV_FIRST;
            lo_restart    <= 1'b1;
            cnt_reg       <= '0;
            i_cnt_reg     <= '0;
            q_cnt_reg     <= '0;
            run_div_reg   <= '0;
            run_mag_reg   <= '0;
            run_first_reg <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_reg == SETTLE_END) begin
            cnt_reg   <= '0;
            state_reg <= ST_INTEG;
          end else begin
            cnt_reg <= cnt_reg + TW'(1);
          end
        end
        ST_INTEG: begin
          i_cnt_reg <= i_sum;
          q_cnt_reg <= q_sum;
          if (cnt_reg == DWELL_END) begin
            cnt_reg   <= '0;
            state_reg <= ST_REPORT;
            res_valid <= 1'b1;
            res_div   <= lo_div;
            res_mag   <= mag;
            // Strict compare keeps the lower divider on ties.
            if (run_first_reg || (mag > run_mag_reg)) begin
              run_div_reg <= lo_div;
              run_mag_reg <= mag;
            end
            run_first_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + TW'(1);
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (lo_div == DIV_LAST) begin
              state_reg <= ST_FINISH;
              done      <= 1'b1;
              best_div  <= run_div_reg;
              best_mag  <= run_mag_reg;
            end else begin
              state_reg  <= ST_SETTLE;
              lo_div     <= lo_div + 8'd1;
              lo_restart <= 1'b1;
              cnt_reg    <= '0;
              i_cnt_reg  <= '0;
              q_cnt_reg  <= '0;
            end
          end
        end
        ST_FINISH: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iq_sweep_ctrl.sv
// Scoreboard bench for iq_sweep_ctrl: the driver queues expected restarts,
// results and sweep-end values; a negedge monitor pops and compares them.
module tb_iq_sweep_ctrl;

  localparam int DIV_MIN = 5;
  localparam int DIV_MAX = 6;
  localparam int SETTLE  = 4;
  localparam int DWELL   = 16;
  localparam int CNT_W   = 16;

  logic             clk_27m = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             i_bit = 1'b0;
  logic             q_bit = 1'b0;
  logic             res_ready = 1'b1;
  logic [7:0]       lo_div;
  logic             lo_restart;
  logic             busy;
  logic             res_valid;
  logic [7:0]       res_div;
  logic [CNT_W:0]   res_mag;
  logic             done;
  logic [7:0]       best_div;
  logic [CNT_W:0]   best_mag;

  iq_sweep_ctrl #(
    .DIV_MIN(DIV_MIN), .DIV_MAX(DIV_MAX), .SETTLE(SETTLE), .DWELL(DWELL), .CNT_W(CNT_W)
  ) dut (
    .clk_27m(clk_27m), .rst_n(rst_n), .start(start), .i_bit(i_bit), .q_bit(q_bit),
    .lo_div(lo_div), .lo_restart(lo_restart), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_div(res_div), .res_mag(res_mag),
    .done(done), .best_div(best_div), .best_mag(best_mag)
  );

  initial forever #5 clk_27m = ~clk_27m;

  int cyc = 0;
  always @(posedge clk_27m) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {int rise; int div; int mag;} res_t;
  typedef struct {int at; int div; int mag;} done_t;
  res_t  exp_res[$];
  done_t exp_done[$];
  int    exp_restart[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_27m);
    #1;
  endtask

  // Monitor: compares every DUT event against the head of its queue.
  initial begin
    bit    prev_valid;
    res_t  e;
    done_t d;
    int    er;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk_27m);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (lo_restart) begin
          if (exp_restart.size() == 0) check("restart_unexpected", cyc, -1);
          else begin
            er = exp_restart.pop_front();
            check("restart_cycle", cyc, er);
          end
        end
        if (res_valid) begin
          if (exp_res.size() == 0) check("res_unexpected", cyc, -1);
          else begin
            e = exp_res[0];
            if (!prev_valid) check("res_valid_rise", cyc, e.rise);
            check("res_div", int'(res_div), e.div);
            check("res_mag", int'(res_mag), e.mag);
            if (res_ready) void'(exp_res.pop_front());
          end
        end
        if (done) begin
          if (exp_done.size() == 0) check("done_unexpected", cyc, -1);
          else begin
            d = exp_done.pop_front();
            check("done_cycle", cyc, d.at);
            check("best_div", int'(best_div), d.div);
            check("best_mag", int'(best_mag), d.mag);
          end
        end
        prev_valid = res_valid;
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while ((exp_restart.size() + exp_res.size() + exp_done.size()) > 0 && n < 300) begin
      tick();
      n++;
    end
    check({name, "_drained"}, exp_restart.size() + exp_res.size() + exp_done.size(), 0);
  endtask

  // mode 0: I=1,Q=0; mode 1: I=Q alternating for the first step then I=Q=1;
  // mode 2: I=Q=1 plus stray start pulses. dly = cycles res_ready is held low
  // after the first result appears.
  task automatic run_sweep(input string name, input int mode, input int dly,
                           input int m1, input int m2, input int bd, input int bm);
    int t, h1, r2, v2, dn;
    t  = cyc;
    h1 = t + 1 + SETTLE + DWELL + dly;
    r2 = h1 + 1;
    v2 = r2 + SETTLE + DWELL;
    dn = v2 + 1;
    exp_restart.push_back(t + 1);
    exp_restart.push_back(r2);
    exp_res.push_back('{t + 1 + SETTLE + DWELL, DIV_MIN, m1});
    exp_res.push_back('{v2, DIV_MAX, m2});
    exp_done.push_back('{dn, bd, bm});
    for (int c = t; c <= dn + 2; c++) begin
      start = (c == t) || (mode == 2 && (c == t + 10 || c == t + 25 || c == t + 40));
      res_ready = !(c >= t + 21 && c < t + 21 + dly);
      case (mode)
        0: begin i_bit = 1'b1; q_bit = 1'b0; end
        1: begin
          if (c < t + 22) begin i_bit = 1'(c % 2); q_bit = 1'(c % 2); end
          else begin i_bit = 1'b1; q_bit = 1'b1; end
        end
        default: begin i_bit = 1'b1; q_bit = 1'b1; end
      endcase
      tick();
    end
    start = 1'b0;
    res_ready = 1'b1;
    check({name, "_busy_idle"}, int'(busy), 0);
    drain(name);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_lo_div", int'(lo_div), DIV_MIN);
    check("rst_busy", int'(busy), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("idle_lo_div", int'(lo_div), DIV_MIN);
    check("idle_lo_restart", int'(lo_restart), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_res_valid", int'(res_valid), 0);
    check("idle_res_div", int'(res_div), 0);
    check("idle_res_mag", int'(res_mag), 0);
    check("idle_done", int'(done), 0);
    check("idle_best_div", int'(best_div), 0);
    check("idle_best_mag", int'(best_mag), 0);

    run_sweep("extremes", 0, 0, 32, 32, 5, 32);
    check("hold_lo_div", int'(lo_div), DIV_MAX);
    repeat (3) tick();
    run_sweep("null_sel", 1, 0, 0, 32, 6, 32);
    repeat (2) tick();
    run_sweep("backpressure", 2, 10, 32, 32, 5, 32);
    repeat (2) tick();

    // Reset during INTEG of the second step.
    t = cyc;
    exp_restart.push_back(t + 1);
    exp_restart.push_back(t + 22);
    exp_res.push_back('{t + 21, DIV_MIN, 32});
    for (int c = t; c < t + 30; c++) begin
      start = (c == t);
      res_ready = 1'b1;
      i_bit = 1'b1;
      q_bit = 1'b0;
      tick();
    end
    check("mid_lo_div_before", int'(lo_div), DIV_MAX);
    rst_n = 1'b0;
    tick();
    check("mid_busy", int'(busy), 0);
    check("mid_res_valid", int'(res_valid), 0);
    check("mid_lo_div", int'(lo_div), DIV_MIN);
    check("mid_best_mag", int'(best_mag), 0);
    check("mid_best_div", int'(best_div), 0);
    check("mid_pending", exp_restart.size() + exp_res.size(), 0);
    exp_restart.delete();
    exp_res.delete();
    exp_done.delete();
    rst_n = 1'b1;
    repeat (5) tick();
    run_sweep("after_reset", 0, 0, 32, 32, 5, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
